rx_symbol_lock_ctrl: RTL and testbench
======================================

// Module: rx_symbol_lock_ctrl
// PURPOSE
//  Receive-side symbol alignment and lock controller placed in front of the 8b/10b decoder.
//  Scans raw deserialiser words for the comma pattern and selects the 10-bit alignment offset fed to the decoder Data_in.
//  Monitors DecodeError/DisparityError returned by the decoder to declare and drop symbol lock.
//  Lock is declared after repeated commas; lock is lost under an error-count/good-run policy.
// PARAMETERS
//  LOCK_COMMAS  4   commas at one offset needed, with no decoder error, to declare lock (>=1)
//  LOSS_ERRS    4   net error count that drops lock (>=1)
//  GOOD_RUN     16  consecutive error-free symbols that decrement the error count
//  DEC_LAT      1   cycles from Data_aligned to the matching decoder error flags
// PORTS
//  CLK             in   1   symbol clock, rising edge
//  Rst_n           in   1   asynchronous active-low reset
//  Raw_in          in   10  unaligned deserialiser word, one per CLK; bit 9 received first
//  Force_realign   in   1   synchronous; forces SEARCH from any state
//  DecodeError     in   1   decoder output; valid DEC_LAT cycles after Data_aligned
//  DisparityError  in   1   decoder output; same timing as DecodeError
//  Data_aligned    out  10  aligned symbol, drives decoder Data_in
//  Align_offset    out  4   current offset, 0..9
//  Symbol_lock     out  1   high in LOCKED
//  Lock_lost       out  1   one-cycle pulse on LOCKED->SEARCH
//  Err_cnt         out  3   current net error count (debug)
// BEHAVIOUR
//  Reset: state=SEARCH; Data_aligned=0, Align_offset=0, Symbol_lock=0, Lock_lost=0, Err_cnt=0.
//  Reset: prev_raw=0; all internal counters=0.
//  Window: win[19:0]={prev_raw,Raw_in}; prev_raw<=Raw_in every cycle.
//  Candidate k = win[19-k -: 10].
//  Data_aligned <= candidate[Align_offset] (registered, 1-cycle latency).
//  Comma: candidate[9:3]==7'b0011111 or 7'b1100000. The lowest k wins if several match.
//  err = (DecodeError|DisparityError) & ~blank.
//  blank: counter loaded with DEC_LAT whenever Align_offset changes; err is masked while the counter is nonzero.
//  SEARCH: comma at k -> Align_offset<=k, comma_cnt<=1, go VERIFY; no comma -> stay.
//  VERIFY, comma at Align_offset: comma_cnt++.
//  VERIFY, comma at a different k: Align_offset<=k, comma_cnt<=1.
//  VERIFY, err: go SEARCH, comma_cnt<=0. err has priority over the comma rules.
//  VERIFY, comma_cnt reaches LOCK_COMMAS: go LOCKED, Symbol_lock<=1.
//  VERIFY, LOCK_COMMAS==1: lock is declared directly from SEARCH.
//  LOCKED: offset frozen; commas at other offsets are ignored.
//  LOCKED, err: Err_cnt++ (saturating), good_cnt<=0.
//  LOCKED, no err: good_cnt++. At GOOD_RUN: good_cnt<=0, and Err_cnt-- if Err_cnt>0.
//  LOCKED, simultaneous err and GOOD_RUN completion: err wins, no decrement.
//  LOCKED, Err_cnt reaching LOSS_ERRS: go SEARCH, Symbol_lock<=0.
//    Lock_lost=1 for that one cycle; Err_cnt and good_cnt cleared.
//  Force_realign: next state SEARCH, counters cleared, Symbol_lock<=0.
//    Force_realign has priority over all other events.
//    Lock_lost pulses only if the block was LOCKED.
//  Align_offset is kept on entry to SEARCH until a new comma is found.
//  Async reset mid-lock: all outputs return to reset values immediately.
// STRUCTURE
//  Package rx_align_pkg:
//    state enum {SEARCH,VERIFY,LOCKED}
//    COMMA_P=7'b0011111, COMMA_N=7'b1100000
//    offset width constant
//  Sub-module rx_comma_detect (combinational):
//    input win[19:0]; outputs comma_any, comma_off[3:0] (lowest k), comma_at[9:0] (per-offset hit vector)
//  Top holds the window register, FSM, comma/error/good/blank counters and output registers.
// TESTING
//  T1: Raw_in=K28.5 (0011111010) every cycle at offset 0, no errors.
//      -> Symbol_lock rises LOCK_COMMAS cycles after the first comma; Align_offset=0.
//  T2: stream shifted by 3 bits. -> Align_offset=3; Data_aligned equals 0011111010 on comma cycles; lock declared.
//  T3: in VERIFY after 2 commas, assert DecodeError (post-blank). -> state SEARCH; Symbol_lock stays 0.
//  T4: locked, inject 4 errors spaced <16 symbols apart. -> Lock_lost one-cycle pulse, Symbol_lock=0, Err_cnt=0.
//  T5: locked, 3 errors then 16 clean symbols then 1 error. -> Err_cnt 3->2->3, lock held.
//      Error coinciding with the 16th good symbol -> Err_cnt increments.
//  T6: Force_realign while LOCKED -> Lock_lost pulse, SEARCH next cycle.
//      Rst_n low mid-lock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rx_align_pkg.sv
// rx_align_pkg: shared state encodings, comma patterns and helpers for the symbol lock controller
package rx_align_pkg;
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;
    localparam int OFF_W = 4;

    function automatic logic is_comma(input logic [9:0] c);
        return (c[9:3] == COMMA_P) || (c[9:3] == COMMA_N);
    endfunction
endpackage

// File: rtl/rx_comma_detect.sv
// rx_comma_detect: flags comma patterns at each of the ten alignment offsets of a 20-bit window
module rx_comma_detect
    import rx_align_pkg::*;
(
    input  logic [19:0]      i_win,
    output logic             o_comma_any,
    output logic [OFF_W-1:0] o_comma_off,
    output logic [9:0]       o_comma_at
);
    always_comb begin
        o_comma_at = '0;
        for (int k = 0; k < 10; k++) o_comma_at[k] = is_comma(i_win[19-k -: 10]);
    end

    // descending scan so the lowest matching offset is the one left standing
    always_comb begin
        o_comma_off = '0;
        for (int k = 9; k >= 0; k--) if (o_comma_at[k]) o_comma_off = OFF_W'(k);
    end

    assign o_comma_any = |o_comma_at;
endmodule

// File: rtl/rx_symbol_lock_ctrl.sv
// rx_symbol_lock_ctrl: comma-based 10-bit alignment with error-count/good-run lock supervision
module rx_symbol_lock_ctrl
    import rx_align_pkg::*;
#(
    parameter int LOCK_COMMAS = 4,
    parameter int LOSS_ERRS   = 4,
    parameter int GOOD_RUN    = 16,
    parameter int DEC_LAT     = 1
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [9:0]       i_raw_in,
    input  logic             i_force_realign,
    input  logic             i_decode_error,
    input  logic             i_disparity_error,
    output logic [9:0]       o_data_aligned,
    output logic [OFF_W-1:0] o_align_offset,
    output logic             o_symbol_lock,
    output logic             o_lock_lost,
    output logic [2:0]       o_err_cnt
);
    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);
    localparam int BW = $clog2(DEC_LAT + 2);

    logic [9:0]       r_prev_raw, r_data;
    logic [1:0]       r_state, w_state_nxt;
    logic [OFF_W-1:0] r_off, w_off_nxt, w_comma_off;
    logic [CW-1:0]    r_cc, w_cc_nxt, w_cc_inc;
    logic [GW-1:0]    r_good, w_good_nxt;
    logic [2:0]       r_err, w_err_nxt, w_err_inc;
    logic [BW-1:0]    r_blank;
    logic             r_lock, w_lock_nxt, r_lost, w_lost_nxt;
    logic [19:0]      w_win;
    logic [9:0]       w_comma_at;
    logic             w_comma_any, w_err, w_good_last;

    assign w_win       = {r_prev_raw, i_raw_in};
    assign w_err       = (i_decode_error | i_disparity_error) & (r_blank == '0);
    assign w_cc_inc    = r_cc + 1'b1;
    assign w_err_inc   = (r_err == 3'd7) ? r_err : r_err + 3'd1;
    assign w_good_last = r_good == GW'(GOOD_RUN - 1);

    rx_comma_detect u_det (
        .i_win       (w_win),
        .o_comma_any (w_comma_any),
        .o_comma_off (w_comma_off),
        .o_comma_at  (w_comma_at)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_off_nxt   = r_off;
        w_cc_nxt    = r_cc;
        w_good_nxt  = r_good;
        w_err_nxt   = r_err;
        w_lock_nxt  = r_lock;
        w_lost_nxt  = 1'b0;
        if (i_force_realign) begin
            w_state_nxt = SEARCH;
            w_cc_nxt    = '0;
            w_good_nxt  = '0;
            w_err_nxt   = '0;
            w_lock_nxt  = 1'b0;
            w_lost_nxt  = r_state == LOCKED;
        end else if (r_state == SEARCH) begin
            if (w_comma_any) begin
                w_off_nxt   = w_comma_off;
                w_cc_nxt    = CW'(1);
                w_state_nxt = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;
                w_lock_nxt  = LOCK_COMMAS == 1;
            end
        end else if (r_state == VERIFY) begin
            if (w_err) begin
                w_state_nxt = SEARCH;
                w_cc_nxt    = '0;
            end else if (w_comma_at[r_off]) begin
                w_cc_nxt    = w_cc_inc;
                w_state_nxt = (w_cc_inc == CW'(LOCK_COMMAS)) ? LOCKED : VERIFY;
                w_lock_nxt  = w_cc_inc == CW'(LOCK_COMMAS);
            end else if (w_comma_any) begin
                w_off_nxt = w_comma_off;
                w_cc_nxt  = CW'(1);
            end
        end else if (r_state == LOCKED) begin
            // an error always resets the good run, even on the symbol that would have completed it
            if (w_err) begin
                w_good_nxt = '0;
                w_err_nxt  = (w_err_inc >= 3'(LOSS_ERRS)) ? 3'd0 : w_err_inc;
                if (w_err_inc >= 3'(LOSS_ERRS)) begin
                    w_state_nxt = SEARCH;
                    w_lock_nxt  = 1'b0;
                    w_lost_nxt  = 1'b1;
                end
            end else begin
                w_good_nxt = w_good_last ? '0 : r_good + 1'b1;
                w_err_nxt  = (w_good_last && r_err != 3'd0) ? r_err - 3'd1 : r_err;
            end
        end else begin
            w_state_nxt = SEARCH;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_raw <= '0;
            r_data     <= '0;
            r_state    <= SEARCH;
            r_off      <= '0;
            r_cc       <= '0;
            r_good     <= '0;
            r_err      <= '0;
            r_blank    <= '0;
            r_lock     <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_prev_raw <= i_raw_in;
            r_data     <= w_win[19 - r_off -: 10];
            r_state    <= w_state_nxt;
            r_off      <= w_off_nxt;
            r_cc       <= w_cc_nxt;
            r_good     <= w_good_nxt;
            r_err      <= w_err_nxt;
            r_lock     <= w_lock_nxt;
            r_lost     <= w_lost_nxt;
            // decoder flags still refer to symbols cut at the old offset for DEC_LAT cycles
            r_blank    <= (w_off_nxt != r_off) ? BW'(DEC_LAT) : r_blank - BW'(r_blank != '0);
        end
    end

    assign o_data_aligned = r_data;
    assign o_align_offset = r_off;
    assign o_symbol_lock  = r_lock;
    assign o_lock_lost    = r_lost;
    assign o_err_cnt      = r_err;
endmodule

// File: tb/tb_rx_symbol_lock_ctrl.sv
// tb_rx_symbol_lock_ctrl: scoreboard bench with a behavioural alignment/lock model and random streams
module tb_rx_symbol_lock_ctrl;
    localparam int LC = 4, LE = 4, GR = 16, DL = 1;
    localparam int M_HUNT = 0, M_CONFIRM = 1, M_LOCK = 2;
    localparam logic [9:0] K = 10'b0011111010;
    localparam logic [9:0] KN = 10'b1100000101;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [9:0] raw = '0;
    logic       fr = 1'b0, de = 1'b0, pe = 1'b0;
    logic [9:0] data;
    logic [3:0] off;
    logic       lock, lost;
    logic [2:0] errc;

    rx_symbol_lock_ctrl #(.LOCK_COMMAS(LC), .LOSS_ERRS(LE), .GOOD_RUN(GR), .DEC_LAT(DL)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_raw_in          (raw),
        .i_force_realign   (fr),
        .i_decode_error    (de),
        .i_disparity_error (pe),
        .o_data_aligned    (data),
        .o_align_offset    (off),
        .o_symbol_lock     (lock),
        .o_lock_lost       (lost),
        .o_err_cnt         (errc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] data;
        logic [3:0] off;
        logic       lock;
        logic       lost;
        logic [2:0] errc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0, miscompares = 0;

    logic [9:0] m_prev, m_data, prev_sym = '0;
    int  m_mode, m_off, m_commas, m_good, m_errs, m_blank;
    bit  m_lock, m_lost;

    function automatic bit is_comma(input logic [9:0] c);
        return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
    endfunction

    // the symbol starting k bits into the 20-bit window (bit 19 oldest)
    function automatic logic [9:0] cand(input logic [19:0] w, input int k);
        logic [19:0] t;
        t = w >> (10 - k);
        return t[9:0];
    endfunction

    task automatic model_reset();
        m_prev = '0; m_data = '0; m_mode = M_HUNT; m_off = 0; m_commas = 0;
        m_good = 0; m_errs = 0; m_blank = 0; m_lock = 0; m_lost = 0;
    endtask

    task automatic model_step(input logic [9:0] r, input bit f, input bit d, input bit p);
        logic [19:0] w;
        int first, old_off;
        bit hit, e;
        w = {m_prev, r};
        first = -1;
        for (int k = 9; k >= 0; k--) if (is_comma(cand(w, k))) first = k;
        hit = is_comma(cand(w, m_off));
        e = (d || p) && (m_blank == 0);
        old_off = m_off;
        m_data = cand(w, m_off);
        m_lost = 0;
        if (f) begin
            m_lost = (m_mode == M_LOCK);
            m_mode = M_HUNT; m_commas = 0; m_good = 0; m_errs = 0; m_lock = 0;
        end else if (m_mode == M_HUNT) begin
            if (first >= 0) begin
                m_off = first; m_commas = 1;
                m_mode = (LC == 1) ? M_LOCK : M_CONFIRM;
                m_lock = (LC == 1);
            end
        end else if (m_mode == M_CONFIRM) begin
            if (e) begin
                m_mode = M_HUNT; m_commas = 0;
            end else if (hit) begin
                m_commas++;
                if (m_commas == LC) begin m_mode = M_LOCK; m_lock = 1; end
            end else if (first >= 0) begin
                m_off = first; m_commas = 1;
            end
        end else begin
            if (e) begin
                m_good = 0;
                m_errs = (m_errs < 7) ? m_errs + 1 : 7;
                if (m_errs >= LE) begin
                    m_mode = M_HUNT; m_lock = 0; m_lost = 1; m_errs = 0;
                end
            end else begin
                m_good++;
                if (m_good == GR) begin
                    m_good = 0;
                    if (m_errs > 0) m_errs--;
                end
            end
        end
        if (m_off != old_off) m_blank = DL;
        else if (m_blank > 0) m_blank--;
        m_prev = r;
    endtask

    task automatic cycle(input logic [9:0] r, input bit f, input bit d, input bit p);
        exp_t x;
        raw = r; fr = f; de = d; pe = p;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_step(r, f, d, p);
        x.data = m_data; x.off = 4'(m_off); x.lock = m_lock; x.lost = m_lost; x.errc = 3'(m_errs);
        sb.push_back(x);
    endtask

    // serial symbol stream, slipped by sh bits relative to the word boundary
    task automatic sym(input logic [9:0] s_val, input int sh, input bit d = 0, input bit p = 0, input bit f = 0);
        logic [19:0] t;
        t = {prev_sym, s_val} >> sh;
        prev_sym = s_val;
        cycle(t[9:0], f, d, p);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({data, off, lock, lost, errc} !== {e.data, e.off, e.lock, e.lost, e.errc}) begin
                    miscompares++;
                    $display("FAIL cycle_check t=%0t got data=%b off=%0d lock=%b lost=%b err=%0d, expected data=%b off=%0d lock=%b lost=%b err=%0d",
                             $time, data, off, lock, lost, errc, e.data, e.off, e.lock, e.lost, e.errc);
                end
            end
        end
    end

    initial begin : stim
        int sh;
        logic [9:0] s;
        model_reset();
        repeat (3) cycle('0, 0, 0, 0);
        rst_n = 1'b1;
        // lock on an aligned comma stream
        repeat (8) sym(K, 0);
        // error accounting while locked: 3 errors, good run decrements, coincident error wins
        repeat (3) begin sym(K, 0, 1); sym(K, 0); sym(K, 0); end
        repeat (16) sym(K, 0);
        sym(K, 0, 0, 1);
        repeat (16) sym(K, 0);
        repeat (15) sym(K, 0);
        sym(K, 0, 1);
        repeat (4) sym(K, 0);
        // loss of lock through closely spaced errors, then relock and lose again
        repeat (4) begin sym(K, 0, 1); repeat (3) sym(K, 0); end
        repeat (8) sym(K, 0);
        repeat (4) begin sym(K, 0, 1); repeat (5) sym(K, 0); end
        // relock, forced realign, relock, then asynchronous reset mid-lock
        repeat (8) sym(K, 0);
        sym(K, 0, 0, 0, 1);
        repeat (8) sym(K, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({data, off, lock, lost, errc} !== 17'd0) begin
            miscompares++;
            $display("FAIL async_reset got data=%b off=%0d lock=%b lost=%b err=%0d, expected all zero", data, off, lock, lost, errc);
        end
        model_reset();
        prev_sym = '0;
        repeat (2) cycle('0, 0, 0, 0);
        rst_n = 1'b1;
        // stream slipped by 3 bits
        repeat (12) sym(K, 3);
        // realign onto a 5-bit slip, error after two commas in VERIFY
        sym(K, 3, 0, 0, 1);
        sym(K, 5); sym(K, 5); sym(K, 5); sym(K, 5, 1);
        repeat (8) sym(KN, 5);
        // randomized traffic
        sh = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) sh = $urandom_range(9);
            s = ($urandom_range(2) == 0) ? ($urandom_range(1) ? K : KN) : 10'($urandom);
            sym(s, sh, $urandom_range(23) == 0, $urandom_range(39) == 0, $urandom_range(299) == 0);
        end
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
